// File: rtl/arb_pkg.sv
// Shared types and AXI4-Lite response codes for the memory read arbiter.
package arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_AR,
        ARB_WAIT_R,
        ARB_ERR,
        ARB_DRAIN
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// AXI4-Lite read channel (AR + R) bundle; master drives address and rready.
interface mem_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/rr_pick2.sv
// Two-way request picker: sole requester wins, ties go to m1 (fixed) or !last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_pri,
    output logic       gnt
);

    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = fixed_pri | ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one AXI4-Lite read port between IFU (m0) and LSU (m1), one transaction
// at a time, with a response watchdog that answers SLVERR for a silent slave.
module mem_rd_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FIXED_PRI = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_rd_arbiter_if.slave  m0,
    mem_rd_arbiter_if.slave  m1,
    mem_rd_arbiter_if.master s,
    output logic            owner,
    output logic            busy,
    output logic            tmo_err
);

    localparam int unsigned CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TIMEOUT_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    arb_state_t       state;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             gnt_c;
    logic             own_rready_c;
    logic             tmo_hit_c;

    rr_pick2 u_pick (
        .req       ({m1.arvalid, m0.arvalid}),
        .last      (last),
        .fixed_pri (FIXED_PRI != 0),
        .gnt       (gnt_c)
    );

    assign own_rready_c = owner ? m1.rready : m0.rready;
    // Fires on the cycle whose edge would bring the counter to TIMEOUT.
    assign tmo_hit_c    = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT_M1));
    assign busy         = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            tmo_err <= 1'b0;
        end else begin
            tmo_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (m0.arvalid || m1.arvalid) begin
                        state <= ARB_AR;
                        owner <= gnt_c;
                    end
                end
                ARB_AR: begin
                    if (s.arvalid && s.arready) begin
                        state <= ARB_WAIT_R;
                        cnt   <= '0;
                    end
                end
                ARB_WAIT_R: begin
                    // A real beat always takes precedence over the watchdog.
                    if (s.rvalid && s.rready) begin
                        state <= ARB_IDLE;
                        last  <= owner;
                    end else if (!s.rvalid && tmo_hit_c) begin
                        state   <= ARB_ERR;
                        tmo_err <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ARB_ERR: begin
                    if (own_rready_c) state <= ARB_DRAIN;
                end
                ARB_DRAIN: begin
                    if (s.rvalid) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Channel routing: only the owner is ever connected; everything is zero in IDLE.
    always_comb begin
        s.araddr   = ADDR_W'(0);
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rdata   = DATA_W'(0);
        m0.rresp   = RESP_OKAY;
        m1.arready = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rdata   = DATA_W'(0);
        m1.rresp   = RESP_OKAY;
        case (state)
            ARB_AR: begin
                if (owner) begin
                    s.araddr   = m1.araddr;
                    s.arvalid  = m1.arvalid;
                    m1.arready = s.arready;
                end else begin
                    s.araddr   = m0.araddr;
                    s.arvalid  = m0.arvalid;
                    m0.arready = s.arready;
                end
            end
            ARB_WAIT_R: begin
                if (owner) begin
                    s.rready  = m1.rready;
                    m1.rvalid = s.rvalid;
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                end else begin
                    s.rready  = m0.rready;
                    m0.rvalid = s.rvalid;
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                end
            end
            ARB_ERR: begin
                if (owner) begin
                    m1.rvalid = 1'b1;
                    m1.rresp  = RESP_SLVERR;
                end else begin
                    m0.rvalid = 1'b1;
                    m0.rresp  = RESP_SLVERR;
                end
            end
            ARB_DRAIN: s.rready = 1'b1;
            default: ;
        endcase
    end

endmodule
